adc_scan_sequencer: RTL and testbench

- Multi-channel scan controller that sits between sample_timer and adc_serial.
- On each sample trigger it walks the enabled ADC channels in ascending order. For each channel it issues one conversion request and waits for the ADC's Avalon-ST result.
- Each result is re-emitted on a single Avalon-ST source tagged with its channel number, so downstream filters and peak detectors can select their channel.

---
 rtl/adc_scan_sequencer.sv | 174 +++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer: walks enabled ADC channels per sample trigger and
// re-emits each conversion result on a channel-tagged Avalon-ST source.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adc_scan_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              sample_trigger,
  output logic              adc_sample,
  output logic [2:0]        adc_channel,
  input  logic [DATA_W-1:0] ast_sink_data,
  input  logic              ast_sink_valid,
  input  logic [1:0]        ast_sink_error,
  output logic [DATA_W-1:0] ast_source_data,
  output logic [2:0]        ast_source_channel,
  output logic              ast_source_valid,
  output logic [1:0]        ast_source_error,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // The counter reaches TIMEOUT-1 on the edge where it currently holds TIMEOUT-2.
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 2);
  localparam logic [1:0] C_ERR_TO  = 2'b11;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_CH-1:0]   r_scan_mask;
  logic [NUM_CH-1:0]   w_cur_onehot;
  logic [NUM_CH-1:0]   w_mask_left;
  logic [7:0]          r_cnt;
  logic [2:0]          r_channel;
  logic                w_accept;
  logic                w_got_valid;
  logic                w_timeout;
  logic                w_done;
  logic [DATA_W-1:0]   r_src_data;
  logic [2:0]          r_src_channel;
  logic                r_src_valid;
  logic [1:0]          r_src_error;
  logic                r_overrun;

  function automatic logic [2:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    w_cur_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cur_onehot[i] = (r_channel == 3'(i));
    end
  end

  assign w_mask_left = r_scan_mask & ~w_cur_onehot;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_got_valid  = 1'b0;
    w_timeout    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sample_trigger && en && (|ch_mask)) begin
          w_accept     = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = en ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!en) begin
          w_state_next = S_IDLE;
        end else begin
          // A result on the timeout cycle still counts as a real conversion.
          w_got_valid = ast_sink_valid;
          w_timeout   = !ast_sink_valid && (r_cnt == C_TO_LAST);
          w_done      = w_got_valid || w_timeout;
          if (w_done) begin
            w_state_next = (|w_mask_left) ? S_ISSUE : S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_scan_mask   <= '0;
      r_channel     <= 3'd0;
      r_cnt         <= 8'd0;
      r_src_data    <= '0;
      r_src_channel <= 3'd0;
      r_src_valid   <= 1'b0;
      r_src_error   <= 2'b00;
      r_overrun     <= 1'b0;
    end else begin
      r_src_valid <= w_done;
      if (w_done) begin
        r_src_data    <= w_got_valid ? ast_sink_data : '0;
        r_src_error   <= w_got_valid ? ast_sink_error : C_ERR_TO;
        r_src_channel <= r_channel;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= 8'd0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_accept) begin
        r_scan_mask <= ch_mask;
        r_channel   <= lowest_set(ch_mask);
      end else if ((r_state != S_IDLE) && !en) begin
        r_scan_mask <= '0;
      end else if (w_done) begin
        r_scan_mask <= w_mask_left;
        if (|w_mask_left) begin
          r_channel <= lowest_set(w_mask_left);
        end
      end

      if (!en) begin
        r_overrun <= 1'b0;
      end else if (sample_trigger && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign adc_sample         = (r_state == S_ISSUE);
  assign adc_channel        = r_channel;
  assign busy               = (r_state != S_IDLE);
  assign overrun            = r_overrun;
  assign ast_source_data    = r_src_data;
  assign ast_source_channel = r_src_channel;
  assign ast_source_valid   = r_src_valid;
  assign ast_source_error   = r_src_error;

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_sequencer: table vectors plus multi-cycle sequences against a
// behavioural ADC model and a result/request scoreboard.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adc_scan_sequencer;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 12;
  localparam int TO     = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [NUM_CH-1:0] ch_mask;
  logic              sample_trigger;
  logic              adc_sample;
  logic [2:0]        adc_channel;
  logic [DATA_W-1:0] ast_sink_data;
  logic              ast_sink_valid;
  logic [1:0]        ast_sink_error;
  logic [DATA_W-1:0] ast_source_data;
  logic [2:0]        ast_source_channel;
  logic              ast_source_valid;
  logic [1:0]        ast_source_error;
  logic              busy;
  logic              overrun;

  adc_scan_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .en                 (en),
    .ch_mask            (ch_mask),
    .sample_trigger     (sample_trigger),
    .adc_sample         (adc_sample),
    .adc_channel        (adc_channel),
    .ast_sink_data      (ast_sink_data),
    .ast_sink_valid     (ast_sink_valid),
    .ast_sink_error     (ast_sink_error),
    .ast_source_data    (ast_source_data),
    .ast_source_channel (ast_source_channel),
    .ast_source_valid   (ast_source_valid),
    .ast_source_error   (ast_source_error),
    .busy               (busy),
    .overrun            (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        ch;
    logic [DATA_W-1:0] data;
    logic [1:0]        err;
  } res_t;

  typedef struct {
    logic        en;
    logic [3:0]  mask;
    int          lat;
    logic [1:0]  err;
    logic        silent;
    int          exp_count;
    int          exp_gap;
  } vec_t;

  res_t       sb_q[$];
  logic [2:0] adc_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_samples = 0;
  int n_strobes = 0;
  int last_sample_cyc = 0;
  int last_strobe_cyc = 0;

  int         adc_lat = 20;
  logic [1:0] adc_err = 2'b00;
  logic       adc_silent = 1'b0;

  logic [2:0]        hold_ch = 3'd0;
  logic [DATA_W-1:0] hold_data = '0;
  logic [1:0]        hold_err = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value %0h, none expected (cycle %0d)", name, act, cyc);
  endtask

  // Reference model: channels visited in ascending order; a reply later than
  // TO-1 cycles after the request (or none) becomes a timeout record.
  task automatic push_scan(input logic [3:0] mask, input int lat, input logic [1:0] err,
                           input logic silent);
    res_t r;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        adc_q.push_back(3'(i));
        r.ch = 3'(i);
        if (silent || lat > TO - 1) begin
          r.data = '0;
          r.err  = 2'b11;
        end else begin
          r.data = 12'(12'h100 + i);
          r.err  = err;
        end
        sb_q.push_back(r);
      end
    end
  endtask

  // ADC model: replies lat cycles after the request with 12'h100+channel.
  initial begin
    logic [2:0] ch;
    int         lat;
    ast_sink_valid = 1'b0;
    ast_sink_data  = '0;
    ast_sink_error = 2'b00;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && adc_sample === 1'b1 && !adc_silent) begin
        ch  = adc_channel;
        lat = adc_lat;
        repeat (lat) @(posedge clk);
        #1;
        ast_sink_valid = 1'b1;
        ast_sink_data  = 12'(12'h100 + ch);
        ast_sink_error = adc_err;
        @(posedge clk);
        #1;
        ast_sink_valid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    res_t r;
    logic [2:0] ec;
    if (reset_n === 1'b1) begin
      if (adc_sample) begin
        n_samples++;
        last_sample_cyc = cyc;
        if (adc_q.size() == 0) fail_unexpected("adc_sample", 32'(adc_channel));
        else begin
          ec = adc_q.pop_front();
          check("adc_channel", 32'(adc_channel), 32'(ec));
        end
      end
      if (ast_source_valid) begin
        n_strobes++;
        last_strobe_cyc = cyc;
        if (sb_q.size() == 0) fail_unexpected("source_strobe", 32'(ast_source_channel));
        else begin
          r = sb_q.pop_front();
          check("src_channel", 32'(ast_source_channel), 32'(r.ch));
          check("src_data", 32'(ast_source_data), 32'(r.data));
          check("src_error", 32'(ast_source_error), 32'(r.err));
          hold_ch   = r.ch;
          hold_data = r.data;
          hold_err  = r.err;
        end
      end else begin
        check("src_hold", {15'd0, ast_source_channel, ast_source_error, ast_source_data},
              {15'd0, hold_ch, hold_err, hold_data});
      end
    end
  end

  task automatic pulse_trigger();
    @(posedge clk); #1 sample_trigger = 1'b1;
    @(posedge clk); #1 sample_trigger = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || adc_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   base_s;
    int   base_a;
    int   n;

    vecs[0] = '{1'b1, 4'b1011, 20, 2'b00, 1'b0, 3, 21};
    vecs[1] = '{1'b1, 4'b0100, 20, 2'b00, 1'b1, 1, 64};
    vecs[2] = '{1'b1, 4'b1111,  1, 2'b01, 1'b0, 4,  2};
    vecs[3] = '{1'b1, 4'b0001, 63, 2'b10, 1'b0, 1, 64};
    vecs[4] = '{1'b1, 4'b0010, 64, 2'b00, 1'b0, 1, 64};
    vecs[5] = '{1'b1, 4'b0000,  5, 2'b00, 1'b0, 0,  0};
    vecs[6] = '{1'b0, 4'b1111,  5, 2'b00, 1'b0, 0,  0};

    reset_n = 1'b0;
    en = 1'b1;
    ch_mask = 4'b1111;
    sample_trigger = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_adc_sample", 32'(adc_sample), 32'd0);
    check("rst_adc_channel", 32'(adc_channel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_src", {15'd0, ast_source_valid, ast_source_channel, ast_source_error, ast_source_data},
          32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_no_sample", 32'(n_samples), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      en         = vecs[i].en;
      ch_mask    = vecs[i].mask;
      adc_lat    = vecs[i].lat;
      adc_err    = vecs[i].err;
      adc_silent = vecs[i].silent;
      base_s     = n_strobes;
      if (vecs[i].en) push_scan(vecs[i].mask, vecs[i].lat, vecs[i].err, vecs[i].silent);
      pulse_trigger();
      wait_done($sformatf("vec%0d", i), 400);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_strobes", i), 32'(n_strobes - base_s), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
      if (vecs[i].exp_gap != 0)
        check($sformatf("vec%0d_gap", i), 32'(last_strobe_cyc - last_sample_cyc),
              32'(vecs[i].exp_gap));
      repeat (4) @(negedge clk);
      en = 1'b1;
    end

    // Overrun: second trigger mid-scan is dropped and flagged.
    @(posedge clk); #1;
    ch_mask = 4'b1111; adc_lat = 10; adc_err = 2'b00; adc_silent = 1'b0;
    base_s = n_strobes; base_a = n_samples;
    push_scan(4'b1111, 10, 2'b00, 1'b0);
    pulse_trigger();
    repeat (5) @(posedge clk);
    pulse_trigger();
    @(negedge clk);
    check("ovr_set", 32'(overrun), 32'd1);
    wait_done("ovr", 400);
    repeat (3) @(negedge clk);
    check("ovr_strobes", 32'(n_strobes - base_s), 32'd4);
    check("ovr_samples", 32'(n_samples - base_a), 32'd4);
    check("ovr_sticky", 32'(overrun), 32'd1);
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk);
    check("ovr_stays_clear", 32'(overrun), 32'd0);

    // Abort during WAIT of channel 1: its late result must vanish.
    @(posedge clk); #1;
    ch_mask = 4'b0011; adc_lat = 30;
    base_s = n_strobes; base_a = n_samples;
    adc_q.push_back(3'd0); adc_q.push_back(3'd1);
    sb_q.push_back('{3'd0, 12'h100, 2'b00});
    pulse_trigger();
    n = 0;
    while (n_strobes == base_s && n < 200) begin @(negedge clk); n++; end
    check("abort_first_result", 32'(n < 200), 32'd1);
    repeat (5) @(posedge clk);
    #1 en = 1'b0;
    repeat (2) @(posedge clk);
    #1 en = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_strobes", 32'(n_strobes - base_s), 32'd1);
    check("abort_samples", 32'(n_samples - base_a), 32'd2);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_queues", 32'(adc_q.size() + sb_q.size()), 32'd0);

    // Mask snapshot: a mid-scan mask change only affects the next trigger.
    @(posedge clk); #1;
    ch_mask = 4'b0011; adc_lat = 8;
    base_s = n_strobes;
    push_scan(4'b0011, 8, 2'b00, 1'b0);
    pulse_trigger();
    repeat (3) @(posedge clk);
    #1 ch_mask = 4'b1100;
    wait_done("snap_a", 300);
    push_scan(4'b1100, 8, 2'b00, 1'b0);
    pulse_trigger();
    wait_done("snap_b", 300);
    repeat (3) @(negedge clk);
    check("snap_strobes", 32'(n_strobes - base_s), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
